// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into
// 32-bit words, writes them sequentially and holds the CPU in reset meanwhile.
module instr_mem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [31:0]      instr_wAddr,
    output logic [31:0]      instr_wData,
    output logic             instr_we,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_reg;
    logic [1:0]       byte_cnt_reg;
    logic [CNT_W-1:0] word_cnt_reg;
    logic [CNT_W-1:0] num_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      waddr_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      checksum_reg;
    logic             error_reg;

    logic             byte_acc;
    logic             start_ok;
    logic             start_acc;
    logic [CNT_W-1:0] word_cnt_next;
    logic [7:0]       lane_byte [3];

    assign byte_acc      = (state_reg == RECV) && rx_valid;
    assign start_ok      = (num_words != '0) && (num_words <= DEPTH_C);
    assign start_acc     = (state_reg == IDLE) && start && start_ok;
    assign word_cnt_next = word_cnt_reg + CNT_W'(1);

    // Lanes 0..2 hold the first three bytes; byte 3 is taken straight from rx_data.
    for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_reg <= '0;
            end else if (start_acc) begin
                lane_reg <= '0;
            end else if (byte_acc && (byte_cnt_reg == 2'(gi))) begin
                lane_reg <= rx_data;
            end
        end

        assign lane_byte[gi] = lane_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            num_reg      <= '0;
            addr_reg     <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            checksum_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            num_reg      <= num_words;
                            addr_reg     <= '0;
                            byte_cnt_reg <= '0;
                            word_cnt_reg <= '0;
                            checksum_reg <= '0;
                            error_reg    <= 1'b0;
                            state_reg    <= RECV;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_acc) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            wdata_reg <= {rx_data, lane_byte[2], lane_byte[1], lane_byte[0]};
                            waddr_reg <= addr_reg;
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    checksum_reg <= checksum_reg ^ wdata_reg;
                    word_cnt_reg <= word_cnt_next;
                    if (word_cnt_next == num_reg) begin
                        state_reg <= DONE;
                    end else begin
                        addr_reg  <= addr_reg + 32'd4;
                        state_reg <= RECV;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status strobes are pure decodes of the state register.
    assign rx_ready    = (state_reg == RECV);
    assign instr_we    = (state_reg == WRITE);
    assign done        = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign cpu_reset   = (state_reg != IDLE);
    assign instr_wAddr = waddr_reg;
    assign instr_wData = wdata_reg;
    assign error       = error_reg;
    assign checksum    = checksum_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed table, corner-case sequences
// and randomized loads compared against a word-level reference model.
module tb_instr_mem_loader;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_words;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [31:0]      instr_wAddr;
    logic [31:0]      instr_wData;
    logic             instr_we;
    logic             cpu_reset;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      checksum;

    instr_mem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .instr_wAddr(instr_wAddr),
        .instr_wData(instr_wData),
        .instr_we   (instr_we),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n = 0;
    int last4_cyc = -10;
    int last_we_cyc = -10;
    logic [63:0] wr_q[$];
    bit err_model = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Observer: records writes and checks strobe timing relative to accepted bytes.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                acc_n = 0;
            end else begin
                if (instr_we) begin
                    wr_q.push_back({instr_wAddr, instr_wData});
                    chk("we_latency", 64'(cyc), 64'(last4_cyc + 1));
                    chk("ready_in_write", 64'(rx_ready), 64'd0);
                    last_we_cyc = cyc;
                end
                if (done) chk("done_latency", 64'(cyc), 64'(last_we_cyc + 1));
                if (rx_valid && rx_ready) begin
                    acc_n++;
                    if (acc_n % 4 == 0) last4_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] xor_all(input logic [31:0] w[$]);
        logic [31:0] x = '0;
        foreach (w[i]) x ^= w[i];
        return x;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_waddr"}, 64'(instr_wAddr), 64'd0);
        chk({tag, "_wdata"}, 64'(instr_wData), 64'd0);
        chk({tag, "_we"}, 64'(instr_we), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Pulses start for one cycle and updates the error model from the count rule.
    task automatic pulse_start(input int n);
        wr_q.delete();
        start     = 1'b1;
        num_words = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n >= 1 && n <= DEPTH) err_model = 1'b0;
        else err_model = 1'b1;
    endtask

    task automatic send_words(input logic [31:0] w[$], input int first, input int last,
                              input int maxgap, input bit randgap);
        for (int i = first; i <= last; i++)
            for (int k = 0; k < 4; k++)
                send_byte(w[i][8*k +: 8], randgap ? int'($urandom_range(0, maxgap)) : maxgap);
    endtask

    task automatic finish_and_check(input logic [31:0] w[$]);
        bit seen = 1'b0;
        int n = w.size();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("post_rx_ready", 64'(rx_ready), 64'd0);
        chk("post_done", 64'(done), 64'd0);
        chk("wr_count", 64'(wr_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk("wr_addr", 64'(wr_q[i][63:32]), 64'(4 * i));
            chk("wr_data", 64'(wr_q[i][31:0]), 64'(w[i]));
        end
        chk("checksum", 64'(checksum), 64'(xor_all(w)));
        chk("error_after_load", 64'(error), 64'(err_model));
        $display("load n=%0d writes=%0d checksum=%h", n, wr_q.size(), checksum);
    endtask

    task automatic do_load(input logic [31:0] w[$], input int maxgap, input bit randgap);
        pulse_start(w.size());
        send_words(w, 0, w.size() - 1, maxgap, randgap);
        finish_and_check(w);
    endtask

    typedef struct {
        int n;
        bit exp_err;
        bit exp_busy;
    } start_vec_t;

    start_vec_t  tbl[6];
    logic [31:0] w[$];

    initial begin
        tbl[0] = '{0,   1'b1, 1'b0};
        tbl[1] = '{65,  1'b1, 1'b0};
        tbl[2] = '{1,   1'b0, 1'b1};
        tbl[3] = '{127, 1'b1, 1'b0};
        tbl[4] = '{3,   1'b0, 1'b1};
        tbl[5] = '{64,  1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; num_words = '0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Basic two-word load, valid held high.
        w = '{32'h004182B3, 32'h404182B3};
        do_load(w, 0, 1'b0);
        chk("basic_checksum_const", 64'(checksum), 64'h40000000);

        // Same load with valid toggling every cycle.
        do_load(w, 1, 1'b0);
        chk("gap_checksum_const", 64'(checksum), 64'h40000000);

        // Full depth, word i = i.
        w.delete();
        for (int i = 0; i < DEPTH; i++) w.push_back(32'(i));
        do_load(w, 0, 1'b0);
        chk("full_last", wr_q[$], {32'h000000FC, 32'h0000003F});
        chk("full_checksum_const", 64'(checksum), 64'd0);

        // Table of start responses; legal entries run to completion.
        foreach (tbl[i]) begin
            pulse_start(tbl[i].n);
            @(negedge clk);
            chk("tbl_error", 64'(error), 64'(tbl[i].exp_err));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].exp_busy));
            $display("start n=%0d error=%0b busy=%0b", tbl[i].n, error, busy);
            if (tbl[i].exp_busy) begin
                @(posedge clk); #1;
                w.delete();
                for (int j = 0; j < tbl[i].n; j++) w.push_back($urandom);
                send_words(w, 0, w.size() - 1, 0, 1'b0);
                finish_and_check(w);
            end
        end

        // Reset after two bytes of word 1, then a clean single-word load.
        pulse_start(2);
        send_words('{32'h11223344, 32'h55667788}, 0, 0, 0, 1'b0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        err_model = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        do_load('{32'h0041F2B3}, 0, 1'b0);

        // start while busy is ignored.
        w.delete();
        for (int j = 0; j < 5; j++) w.push_back($urandom);
        pulse_start(5);
        send_words(w, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; num_words = 7'd2;
        @(posedge clk); #1;
        start = 1'b0;
        send_words(w, 1, 4, 1, 1'b1);
        finish_and_check(w);
        chk("busy_start_no_error", 64'(error), 64'd0);

        // Randomized loads and illegal starts against the model.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                pulse_start(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 127)));
                @(negedge clk);
                chk("rand_illegal_error", 64'(error), 64'(err_model));
                chk("rand_illegal_busy", 64'(busy), 64'd0);
                $display("start illegal error=%0b busy=%0b", error, busy);
                @(posedge clk); #1;
            end else begin
                w.delete();
                for (int j = 0, n = int'($urandom_range(1, 6)); j < n; j++) w.push_back($urandom);
                do_load(w, 2, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
